// File: rtl/tile_mover_pkg.sv
// rtl/tile_mover_pkg.sv - shared game encodings: directions, mover states, screen limits
// Purpose: constants and types shared by the tile mover, the game-control FSM and the renderer.
// Ports: none (package).
package tile_mover_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DONE = 2'd2
    } mover_state_t;

    // Largest legal character-origin coordinates on the playfield.
    localparam int SCREEN_X_MAX = 152;
    localparam int SCREEN_Y_MAX = 112;

endpackage

// File: rtl/tile_mover_if.sv
// rtl/tile_mover_if.sv - command/tick/position bundle between game control, rate divider and mover
// Purpose: groups the mover's handshake and position signals.
// Ports (signals): tick, cmd_valid, cmd_dir[1:0] toward the mover;
//                  cmd_ready, pos_x[7:0], pos_y[6:0], busy, done, blocked from the mover.
// Modports: master = command/tick source side, slave = the mover itself.
interface tile_mover_if;

    logic       tick;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_ready;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic       busy;
    logic       done;
    logic       blocked;

    modport master (
        output tick, cmd_valid, cmd_dir,
        input  cmd_ready, pos_x, pos_y, busy, done, blocked
    );

    modport slave (
        input  tick, cmd_valid, cmd_dir,
        output cmd_ready, pos_x, pos_y, busy, done, blocked
    );

endinterface

// File: rtl/tile_move_check.sv
// rtl/tile_move_check.sv - combinational one-tile move legality check
// Purpose: says whether moving one tile from (i_pos_x, i_pos_y) in i_dir stays on screen.
// Ports: i_pos_x[7:0], i_pos_y[6:0] current origin; i_dir[1:0] direction; o_legal move allowed.
module tile_move_check
    import tile_mover_pkg::*;
#(
    parameter int TILE  = 8,
    parameter int X_MAX = SCREEN_X_MAX,
    parameter int Y_MAX = SCREEN_Y_MAX
) (
    input  logic [7:0] i_pos_x,
    input  logic [6:0] i_pos_y,
    input  logic [1:0] i_dir,
    output logic       o_legal
);

    localparam logic [8:0] TILE9  = 9'(TILE);
    localparam logic [8:0] X_MAX9 = 9'(X_MAX);
    localparam logic [8:0] Y_MAX9 = 9'(Y_MAX);

    // 9-bit operands so pos + TILE can never wrap back into range.
    logic [8:0] w_x9;
    logic [8:0] w_y9;

    assign w_x9 = {1'b0, i_pos_x};
    assign w_y9 = {2'b00, i_pos_y};

    always_comb begin
        o_legal = 1'b0;
        case (dir_t'(i_dir))
            DIR_UP:    o_legal = (w_y9 >= TILE9);
            DIR_DOWN:  o_legal = ((w_y9 + TILE9) <= Y_MAX9);
            DIR_LEFT:  o_legal = (w_x9 >= TILE9);
            DIR_RIGHT: o_legal = ((w_x9 + TILE9) <= X_MAX9);
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/tile_mover.sv
// rtl/tile_mover.sv - moves the character one tile per command, one pixel per tick
// Purpose: accepts a direction command, checks legality, steps the position one pixel per
//          tick until a full tile is covered, then pulses done (with blocked if rejected).
// Ports: clock, resetn (async, active-low);
//        bus (slave): tick, cmd_valid, cmd_dir in; cmd_ready, pos_x, pos_y, busy, done, blocked out.
module tile_mover
    import tile_mover_pkg::*;
#(
    parameter int TILE   = 8,
    parameter int X_MAX  = SCREEN_X_MAX,
    parameter int Y_MAX  = SCREEN_Y_MAX,
    parameter int X_INIT = 0,
    parameter int Y_INIT = 0
) (
    input  logic          clock,
    input  logic          resetn,
    tile_mover_if.slave   bus
);

    mover_state_t r_state, w_state_nxt;
    logic [3:0]   r_remaining, w_remaining_nxt;
    dir_t         r_dir, w_dir_nxt;
    logic         r_blocked, w_blocked_nxt;
    logic [7:0]   r_pos_x, w_pos_x_nxt;
    logic [6:0]   r_pos_y, w_pos_y_nxt;
    logic         w_legal;

    tile_move_check #(
        .TILE  (TILE),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_check (
        .i_pos_x (r_pos_x),
        .i_pos_y (r_pos_y),
        .i_dir   (bus.cmd_dir),
        .o_legal (w_legal)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_remaining <= 4'd0;
            r_dir       <= DIR_UP;
            r_blocked   <= 1'b0;
            r_pos_x     <= 8'(X_INIT);
            r_pos_y     <= 7'(Y_INIT);
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_dir       <= w_dir_nxt;
            r_blocked   <= w_blocked_nxt;
            r_pos_x     <= w_pos_x_nxt;
            r_pos_y     <= w_pos_y_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_dir_nxt       = r_dir;
        w_blocked_nxt   = r_blocked;
        w_pos_x_nxt     = r_pos_x;
        w_pos_y_nxt     = r_pos_y;
        case (r_state)
            S_IDLE: begin
                // cmd_ready is high in IDLE, so cmd_valid alone means accept.
                if (bus.cmd_valid) begin
                    w_dir_nxt = dir_t'(bus.cmd_dir);
                    if (w_legal) begin
                        w_state_nxt     = S_MOVE;
                        w_remaining_nxt = 4'(TILE);
                    end else begin
                        w_state_nxt   = S_DONE;
                        w_blocked_nxt = 1'b1;
                    end
                end
            end
            S_MOVE: begin
                if (bus.tick) begin
                    case (r_dir)
                        DIR_UP:    w_pos_y_nxt = r_pos_y - 7'd1;
                        DIR_DOWN:  w_pos_y_nxt = r_pos_y + 7'd1;
                        DIR_LEFT:  w_pos_x_nxt = r_pos_x - 8'd1;
                        DIR_RIGHT: w_pos_x_nxt = r_pos_x + 8'd1;
                        default:   w_pos_x_nxt = r_pos_x;
                    endcase
                    w_remaining_nxt = r_remaining - 4'd1;
                    if (r_remaining == 4'd1) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_blocked_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs decode state/registers only; no input reaches an output combinationally.
    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_MOVE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.blocked   = (r_state == S_DONE) && r_blocked;
    assign bus.pos_x     = r_pos_x;
    assign bus.pos_y     = r_pos_y;

endmodule

// File: tb/tb_tile_mover.sv
// tb/tb_tile_mover.sv - self-checking bench for tile_mover
module tb_tile_mover;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    tile_mover_if bus ();

    tile_mover dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic       blk;
        logic [7:0] x;
        logic [6:0] y;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ex = 0;
    int   ey = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model: legality from the playfield limits 152 x 112 with an 8-pixel tile.
    task automatic push_model(input logic [1:0] d);
        logic legal;
        exp_t e;
        case (d)
            2'd0:    legal = (ey >= 8);
            2'd1:    legal = (ey + 8 <= 112);
            2'd2:    legal = (ex >= 8);
            default: legal = (ex + 8 <= 152);
        endcase
        if (legal) begin
            case (d)
                2'd0:    ey = ey - 8;
                2'd1:    ey = ey + 8;
                2'd2:    ex = ex - 8;
                default: ex = ex + 8;
            endcase
        end
        e.blk = !legal;
        e.x   = 8'(ex);
        e.y   = 7'(ey);
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int i = 0;
        while (bus.cmd_ready !== 1'b1 && i < 50) begin
            step();
            i++;
        end
        chk("ready_timeout", bus.cmd_ready, 1);
    endtask

    task automatic issue(input logic [1:0] d);
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = d;
        push_model(d);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (bus.done !== 1'b1 && i < budget) begin
            step();
            i++;
        end
        chk("done_timeout", bus.done, 1);
    endtask

    task automatic run_cmd(input logic [1:0] d);
        issue(d);
        wait_done(60);
        step();
        chk("idle_after_cmd", bus.cmd_ready, 1);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expected outcome.
    always @(negedge clock) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_blocked", bus.blocked, e.blk);
                chk("sb_pos_x", bus.pos_x, e.x);
                chk("sb_pos_y", bus.pos_y, e.y);
            end
        end
    end

    initial begin
        bus.tick      = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 2'd0;

        // Reset state
        #12;
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_blocked", bus.blocked, 0);
        chk("rst_pos_x", bus.pos_x, 0);
        chk("rst_pos_y", bus.pos_y, 0);
        resetn = 1'b1;
        step();

        // Up from (0,0) is blocked
        bus.tick = 1'b1;
        issue(2'd0);
        chk("blk_done", bus.done, 1);
        chk("blk_blocked", bus.blocked, 1);
        chk("blk_ready", bus.cmd_ready, 0);
        chk("blk_pos_y", bus.pos_y, 0);
        step();
        chk("blk_idle", bus.cmd_ready, 1);
        chk("blk_done_gone", bus.done, 0);

        // Right with tick held high
        issue(2'd3);
        chk("r_ready_low", bus.cmd_ready, 0);
        chk("r_busy", bus.busy, 1);
        chk("r_no_step_at_accept", bus.pos_x, 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("r_step_x", bus.pos_x, i);
        end
        chk("r_done", bus.done, 1);
        chk("r_not_blocked", bus.blocked, 0);
        chk("r_ready_in_done", bus.cmd_ready, 0);
        step();
        chk("r_ready_again", bus.cmd_ready, 1);
        chk("r_end_x", bus.pos_x, 8);
        chk("r_end_y", bus.pos_y, 0);

        // Down with tick every 5 cycles
        bus.tick = 1'b0;
        issue(2'd1);
        for (int t = 0; t < 8; t++) begin
            repeat (4) begin
                step();
                chk("slow_hold_y", bus.pos_y, t);
                chk("slow_busy", bus.busy, 1);
            end
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            chk("slow_step_y", bus.pos_y, t + 1);
        end
        chk("slow_done", bus.done, 1);
        step();

        // Edge of the playfield: walk to (144,104)
        bus.tick = 1'b1;
        repeat (17) run_cmd(2'd3);
        repeat (12) run_cmd(2'd1);
        chk("edge_start_x", bus.pos_x, 144);
        chk("edge_start_y", bus.pos_y, 104);
        run_cmd(2'd3);
        chk("edge_right_x", bus.pos_x, 152);
        run_cmd(2'd3);
        chk("edge_right_blk_x", bus.pos_x, 152);
        run_cmd(2'd1);
        chk("edge_down_y", bus.pos_y, 112);
        run_cmd(2'd1);
        chk("edge_down_blk_y", bus.pos_y, 112);

        // Reset mid-move at pos_x=5
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        ex = 0;
        ey = 0;
        step();
        issue(2'd3);
        repeat (5) step();
        chk("mid_x5", bus.pos_x, 5);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_x", bus.pos_x, 0);
        chk("mid_rst_y", bus.pos_y, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_ready", bus.cmd_ready, 1);
        void'(sb.pop_back());
        ex = 0;
        step();
        step();
        resetn = 1'b1;
        step();
        run_cmd(2'd1);
        chk("post_rst_x", bus.pos_x, 0);
        chk("post_rst_y", bus.pos_y, 8);

        // cmd_valid held high with changing direction during MOVE
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 2'd3;
        push_model(2'd3);
        step();
        for (int i = 1; i <= 8; i++) begin
            bus.cmd_dir = 2'($urandom_range(0, 2));
            step();
            chk("hold_x", bus.pos_x, i);
            chk("hold_y", bus.pos_y, 8);
        end
        chk("hold_done", bus.done, 1);
        chk("hold_ready_done", bus.cmd_ready, 0);
        bus.cmd_dir = 2'd2;
        step();
        chk("hold_idle", bus.cmd_ready, 1);
        bus.cmd_dir = 2'd1;
        push_model(2'd1);
        step();
        bus.cmd_valid = 1'b0;
        chk("hold_accept_busy", bus.busy, 1);
        wait_done(60);
        step();
        chk("hold_end_x", bus.pos_x, 8);
        chk("hold_end_y", bus.pos_y, 16);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tile_mover.md
Name: tile_mover

Overview:
- Downstream consumer of the rate divider's one-cycle enable pulse.
- Moves the player character one tile per accepted command, advancing one pixel per enable tick.
- Produces the pixel position consumed by the VGA draw/erase logic, plus a done/blocked pulse for the game-control FSM.
- Sits between the game-control FSM (command source) and the rate divider (tick source) on one side, and the renderer on the other.

Parameters:
- TILE, 8: pixels per tile, i.e. pixels moved per command (1..15).
- X_MAX, 152: largest legal x pixel coordinate of the character origin.
- Y_MAX, 112: largest legal y pixel coordinate of the character origin.
- X_INIT, 0: x position after reset.
- Y_INIT, 0: y position after reset.

Ports:
- clock  in  1  system clock (50 MHz).
- resetn  in  1  reset, asynchronous, active-low.
- tick  in  1  single-cycle step enable from the rate divider; may be held high continuously (full-speed mode).
- cmd_valid  in  1  move command present.
- cmd_dir  in  2  direction: 0 up (y-), 1 down (y+), 2 left (x-), 3 right (x+).
- cmd_ready  out  1  high only in IDLE; command accepted on a clock edge where cmd_valid && cmd_ready.
- pos_x  out  8  current x pixel.
- pos_y  out  7  current y pixel.
- busy  out  1  high in MOVE.
- done  out  1  one-cycle pulse when a command completes, whether moved or blocked.
- blocked  out  1  high together with done only if the command was rejected.

Behaviour:
- Reset (async, resetn low): pos_x=X_INIT, pos_y=Y_INIT, state=IDLE, remaining=0, cmd_ready=1, busy=0, done=0, blocked=0.
- Reset asserted mid-move aborts the move immediately and snaps the position back to INIT. No done pulse is issued.
- States: IDLE, MOVE, DONE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE, on accept:
  - Latch cmd_dir.
  - Evaluate legality against the current position, using 9-bit arithmetic so sums never wrap:
    - up illegal if pos_y < TILE
    - down illegal if pos_y + TILE > Y_MAX
    - left illegal if pos_x < TILE
    - right illegal if pos_x + TILE > X_MAX
  - Legal: go to MOVE with remaining=TILE.
  - Illegal: go to DONE with the blocked flag set; the position is unchanged.
- IDLE: tick is ignored. cmd_valid without an accept has no effect.
- MOVE:
  - On each edge with tick=1, step the position by exactly 1 pixel in the latched direction and decrement remaining.
  - If a tick edge sees remaining==1, take the final step and go to DONE.
  - tick=0 holds everything. cmd_valid is ignored (cmd_ready=0).
- DONE: lasts exactly one cycle. done=1, blocked=flag, cmd_ready=0. Clear the flag and return to IDLE.
- Latency:
  - Accept at edge k. The earliest first step is at edge k+1, if tick is high in the MOVE cycle.
  - With tick held high: steps at k+1..k+TILE, done high in the cycle after edge k+TILE, cmd_ready high again after edge k+TILE+1.
  - Blocked command: done/blocked high in the cycle after edge k; IDLE again after edge k+1.
- A tick coinciding with the accept edge does not step. A tick in DONE is ignored.
- The position never leaves [0,X_MAX] x [0,Y_MAX], given that X_INIT/Y_INIT are legal.

Decomposition:
- Shared game package holds:
  - direction encodings DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT, shared with the game-control FSM and renderer
  - state encodings S_IDLE/S_MOVE/S_DONE
  - screen-limit constants backing X_MAX/Y_MAX
- One natural sub-module: tile_move_check, a combinational legality check taking (pos_x, pos_y, dir) and returning a legal flag. It is reused later by the game-control FSM for path previews.

Test Plan:
- Reset with X_INIT=0, Y_INIT=0 and tick tied high; dir=3 (right) issued -> cmd_ready drops the next cycle, pos_x goes 1..8 on 8 consecutive edges, done=1 and blocked=0 for one cycle, then cmd_ready=1 with pos=(8,0).
- At pos (0,0), dir=0 (up) -> done=1 and blocked=1 in the cycle after accept, pos unchanged, back in IDLE 2 cycles after accept.
- tick pulsed once every 5 cycles, dir=1 from (8,0) -> pos_y advances only on tick edges, reaching 8 after 8 ticks (~40 cycles). busy is high throughout and the position is steady between ticks.
- At pos (144,104) with defaults: dir=3 is legal (ends at x=152), then dir=3 again is blocked. dir=1 from y=104 is legal (ends at 112), then blocked.
- resetn pulsed low mid-move at pos_x=5 -> immediately pos=(0,0), busy=0, no done pulse; a new command after release works normally.
- cmd_valid held high with changing cmd_dir during MOVE -> no effect. The next accept happens only in IDLE, and the direction latched is the one present at that edge.
